active_list: RTL and testbench
==============================

Name: active_list

Overview:
- In-order reorder buffer for the dual-issue rename stage.
- Accepts up to 2 renamed instructions per cycle and records each one's previous physical mapping (old_pr).
- Marks entries complete from 2 writeback ports and retires at most 1 entry per cycle, oldest first.
- On retirement it returns old_pr to the free list through if_freed/freed_reg. On a branch recall it squashes all entries younger than the recalled branch.

Parameters:
- AL_DEPTH, 32, number of entries; must be a power of 2.
- PR_W, $clog2(`NUM_PR), physical register index width.
- TAG_W, $clog2(AL_DEPTH), entry tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dispatch_valid[2]  in  1  lane has an instruction to allocate.
- dispatch_uses_rd[2]  in  1  lane writes a destination register.
- dispatch_arch_rd[2]  in  5  architectural destination register.
- dispatch_new_pr[2]  in  PR_W  newly allocated physical register.
- dispatch_old_pr[2]  in  PR_W  previous mapping of arch_rd.
- dispatch_tag[2]  out  TAG_W  tag assigned to each lane (combinational).
- al_stall  out  1  insufficient free entries; no lane is allocated.
- wb_valid[2]  in  1  writeback completion strobe.
- wb_tag[2]  in  TAG_W  tag of the completed entry.
- if_recall  in  1  squash entries younger than recall_tag.
- recall_tag  in  TAG_W  tag of the mispredicted branch; the branch itself is kept.
- commit_stall  in  1  hold retirement this cycle.
- if_freed  out  1  old_pr is being returned this cycle.
- freed_reg  out  PR_W  the register being returned.
- commit_valid  out  1  head entry retires this cycle.
- commit_arch_rd  out  5  arch_rd of the retiring entry.
- commit_new_pr  out  PR_W  new_pr of the retiring entry.
- al_empty  out  1  count == 0.

Behaviour:
- State:
  - entry array of {uses_rd, arch_rd, new_pr, old_pr, done};
  - head and tail, each TAG_W bits, wrapping modulo AL_DEPTH;
  - count, TAG_W+1 bits.
- Reset: head=0, tail=0, count=0, all done bits cleared. Outputs after reset: al_empty=1, commit_valid=0, if_freed=0.
- Dispatch:
  - n = dispatch_valid[0] + dispatch_valid[1].
  - al_stall = (AL_DEPTH - count) < n. The comparison uses count at the start of the cycle; a retirement in the same cycle gives no credit.
  - Allocation is all-or-nothing: both lanes are written or neither is.
  - dispatch_tag[0] = tail; dispatch_tag[1] = tail + dispatch_valid[0]. Lanes are compacted, so a lane-1-only dispatch gets tail.
  - When allocation happens: entries are written with done=0, tail advances by n, count increases by n.
  - When al_stall=1: no state changes, and upstream holds its inputs.
- Writeback: wb_valid[i] sets done[wb_tag[i]] at the clock edge. Both ports may target different entries in the same cycle.
- Retire (combinational output, state updates at the edge):
  - commit_valid = ~al_empty & done[head] & ~commit_stall.
  - if_freed = commit_valid & uses_rd[head]; freed_reg = old_pr[head].
  - When commit_valid: head advances by 1 and count decreases by 1.
  - When commit_valid=0, the values of freed_reg, commit_arch_rd and commit_new_pr are don't-care.
- Recall:
  - tail <= recall_tag + 1.
  - count <= ((recall_tag - head) mod AL_DEPTH) + 1 - commit_valid.
  - Recall has priority over dispatch: dispatch is ignored and al_stall is forced to 1 that cycle.
  - Retirement of the head still proceeds in the recall cycle; recall_tag is always at or younger than head.
  - Writebacks to squashed tags in the recall cycle or later are harmless, because done is cleared again at allocation.
- Wrap-around: all index arithmetic is modulo AL_DEPTH. count distinguishes full (count == AL_DEPTH) from empty.
- Simultaneous events:
  - Dispatch plus retire in one cycle: count changes by n - commit_valid.
  - Writeback to the head entry in a cycle: that entry retires no earlier than the next cycle.

Optional Feature:
- Macro: AL_EXCEPTION_EN.
- With the macro defined:
  - added input wb_exc[2] (1 bit each), latched into a per-entry exc bit together with done;
  - added output exc_flush (1 bit).
  - When the retiring head has exc=1: exc_flush=1, if_freed=0, commit_valid=0.
  - Next cycle: head, tail and count are all reset to empty (head=tail=0, count=0).
- Without the macro: no exc state and no exc ports.

Decomposition:
- riscv_core package holds:
  - `NUM_PR and the AL_DEPTH default;
  - al_entry_t struct {uses_rd, arch_rd, new_pr, old_pr, done, exc};
  - al_tag_t typedef.
- One sub-module, al_ptr_ctrl: head/tail/count update logic, covering dispatch, retire and recall priority. The entry array stays in active_list.

Test Plan:
- Reset, then dispatch 2 lanes with old_pr=40,41 and uses_rd=1,1 → tags 0 and 1, count=2. Then wb_tag 0 and 1 → if_freed in two consecutive cycles with freed_reg=40 then 41; al_empty=1 afterwards.
- Fill to 31 entries, then dispatch 2 → al_stall=1, count stays 31. Dispatch lane1-only → tag 31, count=32. Any further dispatch → al_stall=1.
- Wrap-around: with head=30, dispatch 4 → tags 30, 31, 0, 1. Complete them out of order (1, 0, 31, 30) → retirement order is 30, 31, 0, 1.
- Entries at tags 5..9, branch at tag 6, if_recall with recall_tag=6 while head=5 retires → tail=7, count=1. Same-cycle dispatch is ignored.
- uses_rd=0 entry at head with done=1 → commit_valid=1, if_freed=0. Hold commit_stall=1 for 3 cycles → head unchanged, then retires on release.
- AL_EXCEPTION_EN: 3 entries, the head completes with wb_exc=1 → exc_flush=1, if_freed=0; next cycle count=0, al_empty=1.

Source files
------------

// File: rtl/active_list_pkg.sv
// Shared core types for the active list: physical register sizing, entry layout and tag type.
// Build option AL_EXCEPTION_EN adds a per-entry exception bit.
`ifndef NUM_PR
`define NUM_PR 64
`endif

package riscv_core;

  localparam int NUM_PR           = `NUM_PR;
  localparam int AL_PR_W          = $clog2(NUM_PR);
  localparam int AL_DEPTH_DEFAULT = 32;
  localparam int AL_TAG_W         = $clog2(AL_DEPTH_DEFAULT);

  typedef logic [AL_TAG_W-1:0] al_tag_t;
  typedef logic [AL_PR_W-1:0]  pr_t;

  typedef struct packed {
    logic       uses_rd;
    logic [4:0] arch_rd;
    pr_t        new_pr;
    pr_t        old_pr;
    logic       done;
`ifdef AL_EXCEPTION_EN
    logic       exc;
`endif
  } al_entry_t;

endpackage

// File: rtl/active_list_if.sv
// Dispatch / writeback / recall / commit bundle of the active list.
// Build option AL_EXCEPTION_EN adds wb_exc and exc_flush.
interface active_list_if
  import riscv_core::*;
#(
  parameter int TAG_W = AL_TAG_W,
  parameter int PR_W  = AL_PR_W
);

  logic [1:0]            dispatch_valid;
  logic [1:0]            dispatch_uses_rd;
  logic [1:0][4:0]       dispatch_arch_rd;
  logic [1:0][PR_W-1:0]  dispatch_new_pr;
  logic [1:0][PR_W-1:0]  dispatch_old_pr;
  logic [1:0][TAG_W-1:0] dispatch_tag;
  logic                  al_stall;

  logic [1:0]            wb_valid;
  logic [1:0][TAG_W-1:0] wb_tag;
`ifdef AL_EXCEPTION_EN
  logic [1:0]            wb_exc;
  logic                  exc_flush;
`endif

  logic                  if_recall;
  logic [TAG_W-1:0]      recall_tag;
  logic                  commit_stall;

  logic                  if_freed;
  logic [PR_W-1:0]       freed_reg;
  logic                  commit_valid;
  logic [4:0]            commit_arch_rd;
  logic [PR_W-1:0]       commit_new_pr;
  logic                  al_empty;

  modport master (
    output dispatch_valid, dispatch_uses_rd, dispatch_arch_rd, dispatch_new_pr,
           dispatch_old_pr, wb_valid, wb_tag, if_recall, recall_tag, commit_stall,
`ifdef AL_EXCEPTION_EN
    output wb_exc,
    input  exc_flush,
`endif
    input  dispatch_tag, al_stall, if_freed, freed_reg, commit_valid,
           commit_arch_rd, commit_new_pr, al_empty
  );

  modport slave (
    input  dispatch_valid, dispatch_uses_rd, dispatch_arch_rd, dispatch_new_pr,
           dispatch_old_pr, wb_valid, wb_tag, if_recall, recall_tag, commit_stall,
`ifdef AL_EXCEPTION_EN
    input  wb_exc,
    output exc_flush,
`endif
    output dispatch_tag, al_stall, if_freed, freed_reg, commit_valid,
           commit_arch_rd, commit_new_pr, al_empty
  );

endinterface

// File: rtl/al_ptr_ctrl.sv
// Head/tail/count bookkeeping for the active list: dispatch, retire, recall and (with
// AL_EXCEPTION_EN) exception flush, in that increasing order of priority.
module al_ptr_ctrl #(
  parameter  int AL_DEPTH = 32,
  localparam int TAG_W    = $clog2(AL_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       dispatch_valid,
  input  logic             if_recall,
  input  logic [TAG_W-1:0] recall_tag,
  input  logic             commit_valid,
`ifdef AL_EXCEPTION_EN
  input  logic             exc_flush,
`endif
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count,
  output logic             al_stall,
  output logic             alloc
);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [1:0]       n;
  logic [TAG_W:0]   free_entries;

  assign n            = 2'(dispatch_valid[0]) + 2'(dispatch_valid[1]);
  // Credit is based on the start-of-cycle count; a same-cycle retirement is not counted.
  assign free_entries = (TAG_W+1)'(AL_DEPTH) - count_q;
  assign al_stall     = if_recall | (free_entries < (TAG_W+1)'(n));
  assign alloc        = ~al_stall & (|dispatch_valid);

  // NOTE: every output of a combinational block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    head_d  = head_q + TAG_W'(commit_valid);
    tail_d  = tail_q;
    count_d = count_q - (TAG_W+1)'(commit_valid);
    if (if_recall) begin
      // The branch itself survives, so the list ends right after it.
      tail_d  = recall_tag + TAG_W'(1);
      count_d = {1'b0, recall_tag - head_q} + (TAG_W+1)'(1) - (TAG_W+1)'(commit_valid);
    end else if (alloc) begin
      tail_d  = tail_q + TAG_W'(n);
      count_d = count_q + (TAG_W+1)'(n) - (TAG_W+1)'(commit_valid);
    end
`ifdef AL_EXCEPTION_EN
    if (exc_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;

endmodule

// File: rtl/active_list.sv
// In-order active list (reorder buffer) for dual-issue rename: allocate 2/cycle,
// complete from 2 writeback ports, retire 1/cycle. Option: AL_EXCEPTION_EN.
module active_list
  import riscv_core::*;
#(
  parameter  int AL_DEPTH = AL_DEPTH_DEFAULT,
  localparam int PR_W     = AL_PR_W,
  localparam int TAG_W    = $clog2(AL_DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  active_list_if.slave bus
);

  al_entry_t        entries_q [AL_DEPTH];
  al_entry_t        entries_d [AL_DEPTH];
  al_entry_t        head_entry;
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [TAG_W-1:0] disp_tag [2];
  logic             al_stall, alloc, al_empty;
  logic             retire_ready, commit_valid;
`ifdef AL_EXCEPTION_EN
  logic             exc_flush;
`endif

  al_ptr_ctrl #(.AL_DEPTH(AL_DEPTH)) u_ptr (
    .clk            (clk),
    .reset          (reset),
    .dispatch_valid (bus.dispatch_valid),
    .if_recall      (bus.if_recall),
    .recall_tag     (bus.recall_tag),
    .commit_valid   (commit_valid),
`ifdef AL_EXCEPTION_EN
    .exc_flush      (exc_flush),
`endif
    .head           (head),
    .tail           (tail),
    .count          (count),
    .al_stall       (al_stall),
    .alloc          (alloc)
  );

  // Lanes are compacted: a lane-1-only dispatch takes the tail slot.
  assign disp_tag[0] = tail;
  assign disp_tag[1] = tail + TAG_W'(bus.dispatch_valid[0]);

  assign head_entry   = entries_q[head];
  assign al_empty     = (count == '0);
  assign retire_ready = ~al_empty & head_entry.done & ~bus.commit_stall;
`ifdef AL_EXCEPTION_EN
  assign exc_flush    = retire_ready & head_entry.exc;
  assign commit_valid = retire_ready & ~head_entry.exc;
`else
  assign commit_valid = retire_ready;
`endif

  always_comb begin
    entries_d = entries_q;
    for (int p = 0; p < 2; p++) begin
      if (bus.wb_valid[p]) begin
        entries_d[bus.wb_tag[p]].done = 1'b1;
`ifdef AL_EXCEPTION_EN
        entries_d[bus.wb_tag[p]].exc  = bus.wb_exc[p];
`endif
      end
    end
    // Allocation comes last so a stale writeback to a reused slot cannot mark it done.
    if (alloc) begin
      for (int l = 0; l < 2; l++) begin
        if (bus.dispatch_valid[l]) begin
          entries_d[disp_tag[l]].uses_rd = bus.dispatch_uses_rd[l];
          entries_d[disp_tag[l]].arch_rd = bus.dispatch_arch_rd[l];
          entries_d[disp_tag[l]].new_pr  = bus.dispatch_new_pr[l];
          entries_d[disp_tag[l]].old_pr  = bus.dispatch_old_pr[l];
          entries_d[disp_tag[l]].done    = 1'b0;
`ifdef AL_EXCEPTION_EN
          entries_d[disp_tag[l]].exc     = 1'b0;
`endif
        end
      end
    end
  end

  // NOTE: only the status bits are reset; the payload fields are always rewritten
  // at allocation before they can be read, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < AL_DEPTH; i++) begin
        entries_q[i].done <= 1'b0;
`ifdef AL_EXCEPTION_EN
        entries_q[i].exc  <= 1'b0;
`endif
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  assign bus.dispatch_tag[0] = disp_tag[0];
  assign bus.dispatch_tag[1] = disp_tag[1];
  assign bus.al_stall        = al_stall;
  assign bus.al_empty        = al_empty;
  assign bus.commit_valid    = commit_valid;
  assign bus.if_freed        = commit_valid & head_entry.uses_rd;
  assign bus.freed_reg       = head_entry.old_pr;
  assign bus.commit_arch_rd  = head_entry.arch_rd;
  assign bus.commit_new_pr   = head_entry.new_pr;
`ifdef AL_EXCEPTION_EN
  assign bus.exc_flush       = exc_flush;
`endif

endmodule

// File: tb/tb_active_list.sv
// Directed self-checking bench for active_list: allocation, completion, full/stall,
// wrap-around, recall, commit_stall and (with AL_EXCEPTION_EN) exception flush.
module tb_active_list;
  import riscv_core::*;

  localparam int DEPTH = AL_DEPTH_DEFAULT;
  localparam int TAG_W = $clog2(DEPTH);
  localparam int PR_W  = AL_PR_W;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  active_list_if #(.TAG_W(TAG_W), .PR_W(PR_W)) bus ();

  active_list #(.AL_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid   = '0;
    bus.dispatch_uses_rd = '0;
    bus.dispatch_arch_rd = '0;
    bus.dispatch_new_pr  = '0;
    bus.dispatch_old_pr  = '0;
    bus.wb_valid         = '0;
    bus.wb_tag           = '0;
    bus.if_recall        = 1'b0;
    bus.recall_tag       = '0;
    bus.commit_stall     = 1'b0;
`ifdef AL_EXCEPTION_EN
    bus.wb_exc           = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // arch_rd and new_pr are derived from old_pr so commits can be predicted from it.
  task automatic drive_disp(input logic v0, input logic v1, input logic u0, input logic u1,
                            input int o0, input int o1);
    bus.dispatch_valid      = {v1, v0};
    bus.dispatch_uses_rd    = {u1, u0};
    bus.dispatch_old_pr[0]  = PR_W'(o0);
    bus.dispatch_old_pr[1]  = PR_W'(o1);
    bus.dispatch_arch_rd[0] = 5'(o0);
    bus.dispatch_arch_rd[1] = 5'(o1);
    bus.dispatch_new_pr[0]  = PR_W'(o0 + 1);
    bus.dispatch_new_pr[1]  = PR_W'(o1 + 1);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) drive_disp(1'b1, 1'b1, 1'b1, 1'b1, base + i, base + i + 1);
      else           drive_disp(1'b1, 1'b0, 1'b1, 1'b0, base + i, 0);
      tick();
    end
    idle();
  endtask

  task automatic complete_range(input int start, input int n);
    for (int i = 0; i < n; i += 2) begin
      bus.wb_valid  = (i + 1 < n) ? 2'b11 : 2'b01;
      bus.wb_tag[0] = TAG_W'(start + i);
      bus.wb_tag[1] = TAG_W'(start + i + 1);
      tick();
    end
    bus.wb_valid = '0;
  endtask

  task automatic wb1(input int t);
    bus.wb_valid  = 2'b01;
    bus.wb_tag[0] = TAG_W'(t);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (bus.al_empty) break;
      tick();
    end
    check(tag, bus.al_empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and basic allocate / complete / free.
    do_reset();
    check("rst_empty", bus.al_empty, 1);
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_if_freed", bus.if_freed, 0);

    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 40, 41);
    #1;
    check("basic_tag0", bus.dispatch_tag[0], 0);
    check("basic_tag1", bus.dispatch_tag[1], 1);
    check("basic_stall", bus.al_stall, 0);
    tick();
    idle();
    #1;
    check("basic_not_empty", bus.al_empty, 0);
    check("basic_not_done", bus.commit_valid, 0);

    bus.wb_valid  = 2'b11;
    bus.wb_tag[0] = TAG_W'(0);
    bus.wb_tag[1] = TAG_W'(1);
    #1;
    check("wb_head_same_cycle", bus.commit_valid, 0);
    tick();
    idle();
    #1;
    check("free0_valid", bus.if_freed, 1);
    check("free0_reg", bus.freed_reg, 40);
    check("free0_arch_rd", bus.commit_arch_rd, 8);
    check("free0_new_pr", bus.commit_new_pr, 41);
    tick();
    check("free1_valid", bus.if_freed, 1);
    check("free1_reg", bus.freed_reg, 41);
    tick();
    check("basic_drained", bus.al_empty, 1);
    check("basic_drained_cv", bus.commit_valid, 0);

    // Full boundary: 31 entries, a 2-wide dispatch must stall, a single one fits.
    do_reset();
    fill(31, 10);
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 60, 61);
    #1;
    check("full31_stall2", bus.al_stall, 1);
    tick();
    drive_disp(1'b0, 1'b1, 1'b1, 1'b1, 0, 45);
    #1;
    check("full31_lane1_tag", bus.dispatch_tag[1], 31);
    check("full31_lane1_stall", bus.al_stall, 0);
    tick();
    drive_disp(1'b1, 1'b0, 1'b1, 1'b0, 62, 0);
    #1;
    check("full32_stall1", bus.al_stall, 1);
    tick();
    idle();
    wb1(0);
    tick();
    idle();
    #1;
    check("full_head_retire", bus.commit_valid, 1);
    check("full_head_old_pr", bus.freed_reg, 10);

    // Wrap-around with out-of-order completion.
    do_reset();
    fill(30, 0);
    complete_range(0, 30);
    wait_empty("wrap_pre_drain");
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 60, 61);
    #1;
    check("wrap_tag30", bus.dispatch_tag[0], 30);
    check("wrap_tag31", bus.dispatch_tag[1], 31);
    tick();
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 62, 63);
    #1;
    check("wrap_tag0", bus.dispatch_tag[0], 0);
    check("wrap_tag1", bus.dispatch_tag[1], 1);
    tick();
    idle();
    begin
      int wb_order [4] = '{1, 0, 31, 30};
      for (int k = 0; k < 4; k++) begin
        bus.wb_valid  = 2'b10;
        bus.wb_tag[1] = TAG_W'(wb_order[k]);
        #1;
        check($sformatf("wrap_hold_%0d", k), bus.commit_valid, 0);
        tick();
      end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_retire_cv_%0d", k), bus.commit_valid, 1);
      check($sformatf("wrap_retire_pr_%0d", k), bus.freed_reg, 60 + k);
      tick();
    end
    check("wrap_drained", bus.al_empty, 1);

    // Recall: entries 5..9, branch at 6, head 5 retires in the recall cycle.
    do_reset();
    fill(5, 0);
    complete_range(0, 5);
    wait_empty("recall_pre_drain");
    fill(5, 20);
    wb1(5);
    tick();
    idle();
    bus.if_recall  = 1'b1;
    bus.recall_tag = TAG_W'(6);
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 50, 51);
    #1;
    check("recall_forces_stall", bus.al_stall, 1);
    check("recall_head_retires", bus.commit_valid, 1);
    check("recall_head_pr", bus.freed_reg, 20);
    tick();
    idle();
    drive_disp(1'b1, 1'b1, 1'b1, 1'b1, 50, 51);
    #1;
    check("recall_new_tail", bus.dispatch_tag[0], 7);
    idle();
    wb1(6);
    tick();
    idle();
    #1;
    check("recall_branch_cv", bus.commit_valid, 1);
    check("recall_branch_pr", bus.freed_reg, 21);
    tick();
    check("recall_count1", bus.al_empty, 1);

    // uses_rd=0 head under commit_stall.
    drive_disp(1'b1, 1'b0, 1'b0, 1'b0, 33, 0);
    #1;
    check("nord_tag", bus.dispatch_tag[0], 7);
    tick();
    idle();
    wb1(7);
    tick();
    idle();
    bus.commit_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_hold_%0d", k), bus.commit_valid, 0);
      check($sformatf("stall_kept_%0d", k), bus.al_empty, 0);
      tick();
    end
    bus.commit_stall = 1'b0;
    #1;
    check("nord_cv", bus.commit_valid, 1);
    check("nord_if_freed", bus.if_freed, 0);
    check("nord_new_pr", bus.commit_new_pr, 34);
    check("nord_arch_rd", bus.commit_arch_rd, 1);
    tick();
    check("nord_drained", bus.al_empty, 1);

`ifdef AL_EXCEPTION_EN
    // Exception at the head flushes the whole list.
    do_reset();
    fill(3, 0);
    wb1(0);
    bus.wb_exc = 2'b01;
    tick();
    idle();
    #1;
    check("exc_flush", bus.exc_flush, 1);
    check("exc_if_freed", bus.if_freed, 0);
    check("exc_cv", bus.commit_valid, 0);
    tick();
    check("exc_empty", bus.al_empty, 1);
    drive_disp(1'b1, 1'b0, 1'b1, 1'b0, 5, 0);
    #1;
    check("exc_tail_zero", bus.dispatch_tag[0], 0);
    idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
